// File: rtl/intc_arbiter.sv
// Eight-source priority interrupt arbiter: edge-detected pending register, mask,
// vector base, and a three-state request/acknowledge/end-of-interrupt handshake.
module intc_arbiter #(
    parameter logic [7:0] RESET_MASK = 8'hFF,
    parameter logic [7:0] RESET_BASE = 8'h00
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] irq,
    input  logic       mask_we,
    input  logic [7:0] mask_wd,
    input  logic       base_we,
    input  logic [7:0] base_wd,
    input  logic       inta,
    input  logic       eoi,
    output logic       intr,
    output logic [7:0] vector,
    output logic [7:0] pending,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t     state_q;
    logic [7:0] irq_q;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] mask_q;
    logic [4:0] base_q;
    logic [2:0] id_q;
    logic       intr_q;
    logic [7:0] vector_q;

    logic [7:0] rise;
    logic [7:0] cand;
    logic [7:0] clr;
    logic [2:0] sel_id;

    always_comb begin
        rise   = irq & ~irq_q;
        cand   = pending_q & ~mask_q;
        sel_id = 3'd0;
        // Scan from lowest priority upward so the lowest-numbered bit wins.
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) sel_id = 3'(i);
        end
        clr = 8'h00;
        if (state_q == REQ && inta) clr[id_q] = 1'b1;
        // A fresh edge on the acknowledged source beats its clear.
        pending_d = (pending_q & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= IDLE;
            irq_q     <= 8'h00;
            pending_q <= 8'h00;
            mask_q    <= RESET_MASK;
            base_q    <= RESET_BASE[7:3];
            id_q      <= 3'd0;
            intr_q    <= 1'b0;
            vector_q  <= 8'h00;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
            if (mask_we) mask_q <= mask_wd;
            if (base_we) base_q <= base_wd[7:3];
            case (state_q)
                IDLE: begin
                    if (|cand) begin
                        state_q  <= REQ;
                        id_q     <= sel_id;
                        intr_q   <= 1'b1;
                        vector_q <= {base_q, sel_id};
                    end
                end
                REQ: begin
                    if (inta) begin
                        state_q <= SERVICE;
                        intr_q  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eoi) state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    intr_q  <= 1'b0;
                end
            endcase
        end
    end

    assign intr    = intr_q;
    assign vector  = vector_q;
    assign pending = pending_q;
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_intc_arbiter.sv
// Directed bench for intc_arbiter: hand-computed expectations for each scenario.
module tb_intc_arbiter;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] irq;
    logic       mask_we;
    logic [7:0] mask_wd;
    logic       base_we;
    logic [7:0] base_wd;
    logic       inta;
    logic       eoi;
    logic       intr;
    logic [7:0] vector;
    logic [7:0] pending;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    intc_arbiter dut (
        .clk     (clk),
        .clrn    (clrn),
        .irq     (irq),
        .mask_we (mask_we),
        .mask_wd (mask_wd),
        .base_we (base_we),
        .base_wd (base_wd),
        .inta    (inta),
        .eoi     (eoi),
        .intr    (intr),
        .vector  (vector),
        .pending (pending),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_mask(input logic [7:0] m);
        mask_we = 1'b1;
        mask_wd = m;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; irq = 8'h00; mask_we = 1'b0; mask_wd = 8'h00;
        base_we = 1'b0; base_wd = 8'h00; inta = 1'b0; eoi = 1'b0;
        #2;
        check("rst_intr", intr, 1'b0);
        check("rst_vector", vector, 8'h00);
        check("rst_pending", pending, 8'h00);
        check("rst_busy", busy, 1'b0);
        tick();
        clrn = 1'b1;

        // Basic request / acknowledge / end-of-interrupt on source 3
        mask_we = 1'b1; mask_wd = 8'h00; base_we = 1'b1; base_wd = 8'h57;
        tick();
        mask_we = 1'b0; base_we = 1'b0;
        irq = 8'h08;
        tick();
        check("s3_pending_set", pending, 8'h08);
        check("s3_intr_lat", intr, 1'b0);
        irq = 8'h00;
        tick();
        check("s3_intr", intr, 1'b1);
        check("s3_vector", vector, 8'h53);
        check("s3_busy", busy, 1'b1);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        check("s3_ack_intr", intr, 1'b0);
        check("s3_ack_pending", pending, 8'h00);
        check("s3_ack_vector", vector, 8'h53);
        tick();
        check("s3_service_busy", busy, 1'b1);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("s3_eoi_busy", busy, 1'b0);

        // Simultaneous edges on 5 and 2: 2 first, eoi in REQ ignored
        irq = 8'h24;
        tick();
        check("p_pending", pending, 8'h24);
        irq = 8'h00;
        tick();
        check("p_vec2", vector, 8'h52);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("p_eoi_in_req_intr", intr, 1'b1);
        inta = 1'b1;
        tick();
        inta = 1'b0;
        check("p_pending_after_ack", pending, 8'h20);
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
        check("p_idle_gap_intr", intr, 1'b0);
        tick();
        check("p_vec5_intr", intr, 1'b1);
        check("p_vec5", vector, 8'h55);
        inta = 1'b1; tick(); inta = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // Masked source still pends; unmasking raises it
        wr_mask(8'hFF);
        irq = 8'h02;
        tick();
        irq = 8'h00;
        tick();
        tick();
        check("m_pending", pending, 8'h02);
        check("m_intr_masked", intr, 1'b0);
        wr_mask(8'hFD);
        tick();
        check("m_intr_unmask", intr, 1'b1);
        check("m_vector", vector, 8'h51);
        inta = 1'b1; tick(); inta = 1'b0;
        check("m_pending_clr", pending, 8'h00);
        eoi = 1'b1; tick(); eoi = 1'b0;

        // Latched id holds in REQ; base write does not alter current vector
        wr_mask(8'h00);
        irq = 8'h10;
        tick();
        irq = 8'h00;
        tick();
        check("l_vec4", vector, 8'h54);
        irq = 8'h01;
        tick();
        irq = 8'h00;
        check("l_pending", pending, 8'h11);
        check("l_vec_hold", vector, 8'h54);
        base_we = 1'b1; base_wd = 8'h80;
        tick();
        base_we = 1'b0;
        check("l_vec_base_wr", vector, 8'h54);
        inta = 1'b1; tick(); inta = 1'b0;
        check("l_ack_pending", pending, 8'h01);
        check("l_ack_vector", vector, 8'h54);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        check("l_vec0", vector, 8'h80);
        inta = 1'b1; tick(); inta = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // inta in IDLE ignored
        inta = 1'b1; tick(); inta = 1'b0;
        check("i_inta_idle_busy", busy, 1'b0);

        // Re-rise coinciding with acknowledge keeps pending set
        irq = 8'h40;
        tick();
        irq = 8'h00;
        tick();
        check("r_vec6", vector, 8'h86);
        irq = 8'h40; inta = 1'b1;
        tick();
        irq = 8'h00; inta = 1'b0;
        check("r_pending_kept", pending, 8'h40);
        check("r_intr_ack", intr, 1'b0);
        eoi = 1'b1; tick(); eoi = 1'b0;
        tick();
        check("r_reserve_intr", intr, 1'b1);
        check("r_reserve_vec", vector, 8'h86);
        inta = 1'b1; tick(); inta = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;

        // Asynchronous reset during SERVICE with pending 0x81
        irq = 8'h81;
        tick();
        irq = 8'h00;
        tick();
        check("a_vec0", vector, 8'h80);
        irq = 8'h01; inta = 1'b1;
        tick();
        irq = 8'h00; inta = 1'b0;
        check("a_pending_81", pending, 8'h81);
        check("a_busy_service", busy, 1'b1);
        irq = 8'h04;
        #3;
        clrn = 1'b0;
        #1;
        check("a_intr", intr, 1'b0);
        check("a_pending", pending, 8'h00);
        check("a_busy", busy, 1'b0);
        check("a_vector", vector, 8'h00);
        tick();
        #2;
        clrn = 1'b1;
        // irq[2] held through reset registers as an edge; mask back to 0xFF
        tick();
        check("a_held_edge", pending, 8'h04);
        tick();
        tick();
        check("a_mask_reset_intr", intr, 1'b0);
        wr_mask(8'h00);
        tick();
        check("a_base_reset_intr", intr, 1'b1);
        check("a_base_reset_vec", vector, 8'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/intc_arbiter.md
INTC_ARBITER -- requirements
Module: intc_arbiter

Interface
REQ-001 Parameter RESET_MASK, default 8'hFF, SHALL be the mask register value after reset (1 = source masked).
REQ-002 Parameter RESET_BASE, default 8'h00, SHALL be the vector base register value after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 clrn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 irq  input  8  SHALL be the interrupt request lines; bit 0 has highest priority, bit 7 lowest.
REQ-006 mask_we  input  1  SHALL, when high, write mask_wd into the mask register.
REQ-007 mask_wd  input  8  SHALL be the mask write data.
REQ-008 base_we  input  1  SHALL, when high, write base_wd[7:3] into the vector base register.
REQ-009 base_wd  input  8  SHALL be the base write data; bits [2:0] are ignored.
REQ-010 inta  input  1  SHALL be the CPU interrupt acknowledge, sampled high/low each cycle.
REQ-011 eoi  input  1  SHALL be the single-cycle end-of-interrupt strobe from the handler.
REQ-012 intr  output  1  SHALL be the interrupt request to the CPU.
REQ-013 vector  output  8  SHALL be the interrupt vector {base[7:3], id[2:0]} to the CPU.
REQ-014 pending  output  8  SHALL expose the pending register.
REQ-015 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-016 irq SHALL be edge-detected against a registered copy irq_q; each bit where irq=1 and irq_q=0 at a clock edge sets the matching pending bit at that edge.
REQ-017 Edges on masked sources SHALL still set pending; masking only blocks selection.
REQ-018 The FSM SHALL have states IDLE, REQ and SERVICE.
REQ-019 In IDLE, if (pending & ~mask) != 0 at a clock edge, the FSM SHALL enter REQ at that edge and latch id = index of the lowest-numbered such bit.
REQ-020 On entering REQ, intr SHALL be 1 and vector SHALL be {base[7:3], id}; both SHALL remain stable for the whole REQ state.
REQ-021 The latched id SHALL NOT change in REQ, even if a higher-priority source becomes pending or the selected source becomes masked.
REQ-022 In REQ, inta=1 at a clock edge SHALL clear pending[id], drive intr to 0 and move to SERVICE at that edge; vector holds its value.
REQ-023 In SERVICE, eoi=1 at a clock edge SHALL return the FSM to IDLE; a new selection can occur no earlier than the following edge.
REQ-024 inta in IDLE or SERVICE and eoi in IDLE or REQ SHALL be ignored.
REQ-025 If a new irq edge on source id coincides with its clear in REQ-022, set SHALL win and pending[id] remains 1.
REQ-026 Interrupts SHALL NOT nest; no new request is raised while in SERVICE.
REQ-027 mask_we and base_we SHALL take effect at the clock edge they are sampled; a base write during REQ or SERVICE SHALL NOT alter vector until the next selection.
REQ-028 Selection-to-intr latency SHALL be one cycle: pending visible at edge k gives intr=1 after edge k+1.

Reset
REQ-029 While clrn=0, immediately and independent of clk: intr=0, vector=8'h00, pending=8'h00, busy=0, irq_q=8'h00, FSM=IDLE, mask=RESET_MASK, base=RESET_BASE.
REQ-030 Reset asserted in REQ or SERVICE SHALL abort the transaction with no pending bit retained.
REQ-031 An irq line held high through reset release SHALL register as an edge on the first clock edge after release.

Verification
REQ-032 mask=8'h00, base=8'h50, pulse irq[3] -> intr=1, vector=8'h53; inta=1 -> intr=0, pending[3]=0; eoi -> busy=0.
REQ-033 irq[5] and irq[2] rise on the same edge, mask=8'h00 -> vector id 2 served first; after eoi, id 5 raised next, vector=base|5.
REQ-034 mask=8'hFF, pulse irq[1] -> intr stays 0, pending=8'h02; write mask=8'hFD -> intr=1 with id 1 on the next cycle.
REQ-035 In REQ with id=4, irq[0] rises -> vector unchanged (id 4) until inta; id 0 served after eoi.
REQ-036 clrn pulsed low during SERVICE with pending=8'h81 -> intr=0, pending=8'h00, busy=0, mask=RESET_MASK asynchronously.
REQ-037 irq[6] re-rises on the same edge as inta acknowledges id 6 -> pending[6]=1 after that edge, re-served after eoi.
